// File: rtl/freq_duty_gen_if.sv
// Configuration handshake for freq_duty_gen.
// The master offers a frequency/duty pair with cfg_valid and keeps it stable
// until the slave accepts it with cfg_ready.
interface freq_duty_gen_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [33:0] cfg_freq;
  logic [7:0]  cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_freq,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_freq,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/freq_duty_gen.sv
// freq_duty_gen: programmable square-wave / PWM source.
// A requested frequency (Hz) and duty (percent) arrive over the cfg handshake.
// One shared restoring divider works them into period and high-time counts in
// sys_clk cycles. It runs 34 steps for CLK_FREQ/freq and 42 steps for
// period*duty/100. The new counts take effect only at a period boundary, so
// clk_out never produces a runt pulse.
// Optional build macro GEN_PERIOD_CNT_EN adds the period_cnt output. That
// output counts completed periods since the last apply.
module freq_duty_gen #(
  parameter logic [33:0] CLK_FREQ   = 34'd50_000_000,
  parameter logic [33:0] MIN_PERIOD = 34'd2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  freq_duty_gen_if.slave     cfg,
  output logic               clk_out,
  output logic               active,
  output logic               cfg_err
`ifdef GEN_PERIOD_CNT_EN
  ,
  output logic [31:0]        period_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    DIV_PER,
    CLAMP,
    DIV_DUTY,
    WAIT_APPLY
  } state_t;

  state_t      state_reg;
  logic        cfg_ready_reg;
  logic        cfg_err_reg;
  logic [41:0] div_quot_reg;    // dividend shifts out at the top, quotient shifts in at the bottom
  logic [33:0] div_rem_reg;
  logic [33:0] div_den_reg;
  logic [5:0]  step_reg;
  logic        freq_zero_reg;
  logic [7:0]  duty_reg;
  logic [33:0] period_n_reg;
  logic        settle_reg;      // set after the first WAIT_APPLY cycle; idle outputs apply one cycle later

  logic [33:0] period_reg;
  logic [33:0] high_reg;
  logic [33:0] cnt_reg;
  logic        clk_out_reg;
  logic        active_reg;

  logic [34:0] rem_shift;
  logic [33:0] rem_diff;
  logic        div_ge;

  logic [33:0] period_raw;
  logic [33:0] period_clamped;
  logic [7:0]  duty_clamped;
  logic        clamp_err;
  logic [41:0] product;

  logic [33:0] period_last;
  logic        wrap;
  logic        apply_now;
  logic [33:0] period_next;
  logic [33:0] high_next;
  logic [33:0] cnt_next;

  // One restoring-division step: shift the next dividend bit into the remainder and subtract if it fits
  assign rem_shift = {div_rem_reg, div_quot_reg[41]};
  assign rem_diff  = 34'(rem_shift - {1'b0, div_den_reg});
  assign div_ge    = (rem_shift >= {1'b0, div_den_reg});

  // Clamp the raw period and the duty, then form the product that the second division divides by 100
  always_comb begin
    period_raw     = div_quot_reg[33:0];
    period_clamped = period_raw;
    duty_clamped   = duty_reg;
    clamp_err      = 1'b0;
    if (freq_zero_reg) begin
      period_clamped = '0;
    end else if (period_raw < MIN_PERIOD) begin
      period_clamped = MIN_PERIOD;
      clamp_err      = 1'b1;
    end
    if (duty_reg > 8'd100) begin
      duty_clamped = 8'd100;
      clamp_err    = 1'b1;
    end
    product = 42'(period_clamped) * 42'(duty_clamped);
  end

  assign period_last = period_reg - 34'd1;
  assign wrap        = (period_reg != '0) && (cnt_reg == period_last);
  assign apply_now   = (state_reg == WAIT_APPLY) && (active_reg ? wrap : settle_reg);

  // Next waveform counters; an apply restarts the count at 0 with the new values
  always_comb begin
    period_next = period_reg;
    high_next   = high_reg;
    cnt_next    = cnt_reg;
    if (apply_now) begin
      period_next = period_n_reg;
      high_next   = div_quot_reg[33:0];
      cnt_next    = '0;
    end else if (period_reg == '0) begin
      cnt_next = '0;
    end else if (wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 34'd1;
    end
  end

  // Control FSM: handshake, the two division passes, clamping, and waiting for the apply point
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      cfg_ready_reg <= 1'b1;
      cfg_err_reg   <= 1'b0;
      div_quot_reg  <= '0;
      div_rem_reg   <= '0;
      div_den_reg   <= '0;
      step_reg      <= '0;
      freq_zero_reg <= 1'b0;
      duty_reg      <= '0;
      period_n_reg  <= '0;
      settle_reg    <= 1'b0;
    end else begin
      cfg_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg.cfg_valid && cfg_ready_reg) begin
            cfg_ready_reg <= 1'b0;
            div_den_reg   <= cfg.cfg_freq;
            div_quot_reg  <= {CLK_FREQ, 8'd0};
            div_rem_reg   <= '0;
            step_reg      <= 6'd33;
            freq_zero_reg <= (cfg.cfg_freq == '0);
            duty_reg      <= cfg.cfg_duty;
            state_reg     <= DIV_PER;
          end
        end
        DIV_PER: begin
          div_quot_reg <= {div_quot_reg[40:0], div_ge};
          div_rem_reg  <= div_ge ? rem_diff : rem_shift[33:0];
          if (step_reg == '0) begin
            state_reg <= CLAMP;
          end else begin
            step_reg <= step_reg - 6'd1;
          end
        end
        CLAMP: begin
          period_n_reg <= period_clamped;
          cfg_err_reg  <= clamp_err;
          div_quot_reg <= product;
          div_rem_reg  <= '0;
          div_den_reg  <= 34'd100;
          step_reg     <= 6'd41;
          state_reg    <= DIV_DUTY;
        end
        DIV_DUTY: begin
          div_quot_reg <= {div_quot_reg[40:0], div_ge};
          div_rem_reg  <= div_ge ? rem_diff : rem_shift[33:0];
          if (step_reg == '0) begin
            settle_reg <= 1'b0;
            state_reg  <= WAIT_APPLY;
          end else begin
            step_reg <= step_reg - 6'd1;
          end
        end
        WAIT_APPLY: begin
          settle_reg <= 1'b1;
          if (apply_now) begin
            cfg_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Waveform generator: clk_out is registered from the next count, so it stays in phase with cnt
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_reg  <= '0;
      high_reg    <= '0;
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      period_reg  <= period_next;
      high_reg    <= high_next;
      cnt_reg     <= cnt_next;
      clk_out_reg <= (period_next != '0) && (cnt_next < high_next);
      active_reg  <= (period_next != '0);
    end
  end

`ifdef GEN_PERIOD_CNT_EN
  logic [31:0] period_cnt_reg;

  // Completed-period counter, restarted whenever new settings take effect
  always_ff @(posedge sys_clk) begin
    if (sys_rst || apply_now) begin
      period_cnt_reg <= '0;
    end else if (wrap) begin
      period_cnt_reg <= period_cnt_reg + 32'd1;
    end
  end

  assign period_cnt = period_cnt_reg;
`endif

  assign cfg.cfg_ready = cfg_ready_reg;
  assign clk_out       = clk_out_reg;
  assign active        = active_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_freq_duty_gen.sv
// Directed testbench for freq_duty_gen (CLK_FREQ = 50 MHz, MIN_PERIOD = 2).
// Also covers period_cnt when built with GEN_PERIOD_CNT_EN.
module tb_freq_duty_gen;
  logic sys_clk;
  logic sys_rst;
  logic clk_out;
  logic active;
  logic cfg_err;
`ifdef GEN_PERIOD_CNT_EN
  logic [31:0] period_cnt;
`endif

  freq_duty_gen_if ifc ();

  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;

  freq_duty_gen #(
    .CLK_FREQ   (34'd50_000_000),
    .MIN_PERIOD (34'd2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cfg     (ifc),
    .clk_out (clk_out),
    .active  (active),
    .cfg_err (cfg_err)
`ifdef GEN_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Count every cycle in which cfg_err is high
  always @(negedge sys_clk) begin
    if (cfg_err === 1'b1) err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (ifc.cfg_ready !== 1'b1 && n < limit) begin
      n++;
      tick(1);
    end
  endtask

  task automatic send_cfg(input logic [33:0] f, input logic [7:0] d);
    int n;
    wait_ready(500, n);
    check("send_ready_wait", 64'(n < 500), 64'd1);
    ifc.cfg_freq  = f;
    ifc.cfg_duty  = d;
    ifc.cfg_valid = 1'b1;
    tick(1);
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic run_len(input logic lvl, input int limit, output int n);
    n = 0;
    while (clk_out === lvl && n < limit) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int   n;
    int   e0;
    int   mism;
    int   rise;
    int   bad;
    logic expv;

    sys_rst       = 1'b1;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_freq  = '0;
    ifc.cfg_duty  = '0;
    tick(3);
    sys_rst = 1'b0;
    tick(1);
    check("rst_cfg_ready", ifc.cfg_ready, 1);
    check("rst_clk_out", clk_out, 0);
    check("rst_active", active, 0);
    check("rst_cfg_err", cfg_err, 0);
    $display("[TB] reset checked");

    // 1 MHz / 50 %: period 50, high 25, applied one cycle after the divider finishes
    e0 = err_pulses;
    send_cfg(34'd1_000_000, 8'd50);
    wait_ready(200, n);
    check("t1_ready_low_cycles", n, 79);
    check("t1_active", active, 1);
    check("t1_clk_out_at_apply", clk_out, 1);
    run_len(1'b1, 100, n);
    check("t1_high_len", n, 25);
    run_len(1'b0, 100, n);
    check("t1_low_len", n, 25);
    $display("[TB] cfg 1MHz/50 applied, 25 high / 25 low");

    // Offer 2 MHz / 75 % at cnt=10; the old period must finish, then 25/18 at the wrap
    mism = 0;
    rise = -1;
    for (int t = 1; t <= 160; t++) begin
      tick(1);
      if (t == 11) ifc.cfg_valid = 1'b0;
      if (t < 100) expv = ((t % 50) < 25);
      else         expv = (((t - 100) % 25) < 18);
      if (clk_out !== expv) mism++;
      if (rise < 0 && t > 11 && ifc.cfg_ready === 1'b1) rise = t;
      if (t == 10) begin
        ifc.cfg_freq  = 34'd2_000_000;
        ifc.cfg_duty  = 8'd75;
        ifc.cfg_valid = 1'b1;
      end
    end
    check("t3_apply_at_wrap", rise, 100);
    check("t3_wave_mismatches", mism, 0);
    check("t3_no_err", err_pulses - e0, 0);
    $display("[TB] cfg 2MHz/75 switched at period boundary");

    // 3 MHz / 30 %: period truncates to 16, high to 4
    e0 = err_pulses;
    send_cfg(34'd3_000_000, 8'd30);
    wait_ready(200, n);
    check("t2_ready_timeout", 64'(n < 200), 64'd1);
    run_len(1'b1, 100, n);
    check("t2_high_len", n, 4);
    run_len(1'b0, 100, n);
    check("t2_low_len", n, 12);
    run_len(1'b1, 100, n);
    check("t2_high_len_again", n, 4);
    check("t2_no_err", err_pulses - e0, 0);
    $display("[TB] cfg 3MHz/30 gives 4 high / 12 low");

    // 30 MHz / 150 %: both clamps apply, giving one err pulse, period 2, and a constant high
    e0 = err_pulses;
    send_cfg(34'd30_000_000, 8'd150);
    wait_ready(200, n);
    check("t4_ready_timeout", 64'(n < 200), 64'd1);
    check("t4_err_pulses", err_pulses - e0, 1);
    check("t4_active", active, 1);
    run_len(1'b1, 20, n);
    check("t4_const_high", n, 20);
    $display("[TB] cfg 30MHz/150 clamped");

    // freq 0 disables the output
    e0 = err_pulses;
    send_cfg(34'd0, 8'd50);
    wait_ready(200, n);
    check("t5_ready_timeout", 64'(n < 200), 64'd1);
    check("t5_active_at_apply", active, 0);
    check("t5_clk_out_at_apply", clk_out, 0);
    tick(5);
    check("t5_active_later", active, 0);
    check("t5_clk_out_later", clk_out, 0);
    check("t5_no_err", err_pulses - e0, 0);
    $display("[TB] cfg freq 0 disables output");

    // 1 MHz / 0 %: running but constant low
    send_cfg(34'd1_000_000, 8'd0);
    wait_ready(200, n);
    check("t5b_ready_low_cycles", n, 79);
    check("t5b_active", active, 1);
    run_len(1'b0, 120, n);
    check("t5b_const_low", n, 120);
    $display("[TB] cfg 1MHz/0 constant low while active");

    // Reset during the duty division discards the pending config
    send_cfg(34'd2_000_000, 8'd75);
    tick(50);
    sys_rst = 1'b1;
    tick(1);
    check("t6_cfg_ready", ifc.cfg_ready, 1);
    check("t6_clk_out", clk_out, 0);
    check("t6_active", active, 0);
    check("t6_cfg_err", cfg_err, 0);
`ifdef GEN_PERIOD_CNT_EN
    check("t6_period_cnt", period_cnt, 0);
`endif
    sys_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (active !== 1'b0 || ifc.cfg_ready !== 1'b1 || clk_out !== 1'b0) bad++;
    end
    check("t6_never_applied", bad, 0);
    $display("[TB] reset during division discarded config");

`ifdef GEN_PERIOD_CNT_EN
    send_cfg(34'd1_000_000, 8'd50);
    wait_ready(200, n);
    check("pc_ready_low_cycles", n, 79);
    check("pc_zero_at_apply", period_cnt, 0);
    tick(5000);
    check("pc_after_100_periods", period_cnt, 100);
    $display("[TB] period_cnt after 100 periods checked");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/freq_duty_gen.md
Name: freq_duty_gen

Overview:
- Programmable square-wave/PWM source; the transmit-side counterpart of the frequency/duty meter.
- Accepts a target frequency (Hz) and duty (percent) over a valid/ready handshake.
- Derives period and high-time counts in sys_clk cycles with a sequential divider.
- Drives clk_out glitch-free, switching to new settings only at a period boundary; used as stimulus for the meter on-board and in loopback tests.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz (34-bit unsigned).
- MIN_PERIOD, 2, minimum period in sys_clk cycles; higher requested frequencies clamp to this.

Ports:
- sys_clk  input  1  sole clock.
- sys_rst  input  1  synchronous active-high reset.
- cfg_valid  input  1  new configuration offered.
- cfg_ready  output  1  block can accept a configuration.
- cfg_freq  input  34  requested frequency, Hz.
- cfg_duty  input  8  requested high-time, percent (0..100).
- clk_out  output  1  generated waveform, registered.
- active  output  1  high while a nonzero-period waveform is running.
- cfg_err  output  1  one-cycle pulse when a config was clamped.

Behaviour:
- One clock (sys_clk); reset is synchronous, active-high (sys_rst). All state updates on the posedge of sys_clk.
- Reset values: cfg_ready=1, clk_out=0, active=0, cfg_err=0; period_q=0, high_q=0, cnt=0, FSM=IDLE. Reset mid-calculation discards the pending config.
- Handshake: config is accepted when cfg_valid&&cfg_ready, and cfg_freq/cfg_duty are captured in that cycle. cfg_ready drops the next cycle and stays low until the config is applied.
- FSM states and transitions:
  - IDLE: waits for a handshake.
  - DIV_PER: 34-cycle restoring division, period_n = floor(CLK_FREQ/cfg_freq).
  - CLAMP: 1 cycle.
    - If freq==0, set period_n=0 and high_n=0.
    - Else, if period_n<MIN_PERIOD, set period_n=MIN_PERIOD and pulse cfg_err.
    - If duty>100, use duty=100 and pulse cfg_err. This is the same single pulse, even if both clamps apply.
    - Forms the 42-bit product period_n*duty.
  - DIV_DUTY: 42-cycle division by 100, high_n = floor(product/100).
  - WAIT_APPLY: holds period_n/high_n until the apply point, then returns to IDLE.
- Fixed compute latency: accept cycle + 34 + 1 + 42 = WAIT_APPLY entered 78 cycles after acceptance.
- Apply point:
  - If active=0: the cycle after entering WAIT_APPLY.
  - Else: the cycle where cnt==period_q-1.
  - On apply: period_q<=period_n, high_q<=high_n, cnt<=0, cfg_ready<=1.
- Waveform:
  - When period_q!=0: cnt counts 0..period_q-1 and wraps to 0.
  - clk_out<=(cnt<high_q). Each period starts with its high phase.
  - duty 0 gives a constant low; high_q==period_q gives a constant high.
  - active=(period_q!=0).
- Disable: period_q==0 forces cnt=0, clk_out=0, active=0.
- No runt pulses: a period in progress always completes with its old values.
- cfg_valid while cfg_ready=0 is ignored; the source must hold cfg_valid.
- Odd splits truncate toward fewer high cycles; no rounding.

Optional Feature:
- Macro: GEN_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [31:0].
  - It increments on every wrap of cnt (cnt==period_q-1 with period_q!=0), wraps at 2^32-1→0, and clears on reset and on every apply.
  - Lets the bench cross-check the meter gate count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then cfg freq=1_000_000 duty=50 (CLK_FREQ=50M) → cfg_ready low 79 cycles; then period 50, clk_out 25 high/25 low; active=1; cfg_err=0.
- freq=3_000_000 duty=30 → period 16 (truncated), high 4; clk_out 4 high/12 low repeating.
- Running at period 50, new cfg freq=2_000_000 duty=75 offered at cnt=10 → old period completes intact; new period 25/high 18 starts exactly at wrap; no pulse shorter than 18 high or 7 low.
- freq=30_000_000 duty=150 → single cfg_err pulse; period 2, high 2; clk_out constant 1.
- freq=0 → at apply clk_out=0, active=0; next cfg freq=1_000_000 duty=0 → active=1, clk_out stays 0.
- Assert sys_rst during DIV_DUTY → all outputs at reset values next cycle; cfg_ready=1; the old config is never applied. With GEN_PERIOD_CNT_EN, period_cnt=100 after 100 periods of 50 cycles.
